// File: rtl/window_reg_file_if.sv
// Bus between the ALU control decoder / datapath and the windowed register file.
// The master drives window control, write-back and read addresses; the slave returns read data and CWP.
interface window_reg_file_if #(
   parameter int WIDTH = 8
);
   logic [1:0]       window;
   logic             ldWnd;
   logic             nop;
   logic             regWrite;
   logic [1:0]       wrAddr;
   logic [WIDTH-1:0] wrData;
   logic [1:0]       rdAddr0;
   logic [1:0]       rdAddr1;
   logic [WIDTH-1:0] rdData0;
   logic [WIDTH-1:0] rdData1;
   logic [1:0]       curWnd;

   modport master (
      output window, ldWnd, nop, regWrite, wrAddr, wrData, rdAddr0, rdAddr1,
      input  rdData0, rdData1, curWnd
   );

   modport slave (
      input  window, ldWnd, nop, regWrite, wrAddr, wrData, rdAddr0, rdAddr1,
      output rdData0, rdData1, curWnd
   );
endinterface

// File: rtl/window_reg_file.sv
// Windowed register file: 4 logical registers per window mapped onto 8 overlapping
// physical registers, with combinational reads and single-edge write-back / window load.
module window_reg_file #(
   parameter int WIDTH = 8
) (
   input logic              clk,
   input logic              rst,
   window_reg_file_if.slave bus
);
   logic [1:0]       cwp_reg;
   logic [WIDTH-1:0] phys_reg [8];
   logic             we;
   logic [2:0]       wr_idx;
   logic [2:0]       rd_idx0;
   logic [2:0]       rd_idx1;

   // Physical index wraps naturally in 3 bits, so window 3 spills onto P0/P1.
   always_comb begin
      we      = bus.regWrite & bus.nop & ~rst;
      wr_idx  = {cwp_reg, 1'b0} + {1'b0, bus.wrAddr};
      rd_idx0 = {cwp_reg, 1'b0} + {1'b0, bus.rdAddr0};
      rd_idx1 = {cwp_reg, 1'b0} + {1'b0, bus.rdAddr1};
   end

   // The write index above uses the pre-edge CWP, so a same-edge ldWnd cannot redirect it.
   always_ff @(posedge clk) begin
      if (rst) begin
         cwp_reg <= 2'd0;
      end else if (bus.ldWnd) begin
         cwp_reg <= bus.window;
      end
   end

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_phys
         always_ff @(posedge clk) begin
            if (rst) begin
               phys_reg[gi] <= '0;
            end else if (we && (wr_idx == 3'(gi))) begin
               phys_reg[gi] <= bus.wrData;
            end
         end
      end
   endgenerate

   // No bypass: a read during a write returns the value held before the edge.
   assign bus.rdData0 = phys_reg[rd_idx0];
   assign bus.rdData1 = phys_reg[rd_idx1];
   assign bus.curWnd  = cwp_reg;
endmodule

// File: tb/tb_window_reg_file.sv
// Self-checking bench for window_reg_file: directed scenarios plus randomized traffic
// compared against an array-based model of the windowed register file.
module tb_window_reg_file;
   localparam int WIDTH = 8;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   logic [WIDTH-1:0] model_phys [8];
   int               model_cwp;

   window_reg_file_if #(.WIDTH(WIDTH)) bus ();

   window_reg_file #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] model_read(input logic [1:0] a);
      return model_phys[(2 * model_cwp + int'(a)) % 8];
   endfunction

   // Update the model from the currently driven inputs, then take one clock edge.
   task automatic step();
      if (rst) begin
         model_cwp = 0;
         for (int i = 0; i < 8; i++) model_phys[i] = '0;
      end else begin
         if (bus.regWrite && bus.nop)
            model_phys[(2 * model_cwp + int'(bus.wrAddr)) % 8] = bus.wrData;
         if (bus.ldWnd) model_cwp = int'(bus.window);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cycle(input logic r, input logic ld, input logic [1:0] w, input logic rw,
                        input logic np, input logic [1:0] wa, input logic [WIDTH-1:0] wd);
      rst = r; bus.ldWnd = ld; bus.window = w; bus.regWrite = rw;
      bus.nop = np; bus.wrAddr = wa; bus.wrData = wd;
      step();
      rst = 1'b0; bus.ldWnd = 1'b0; bus.regWrite = 1'b0; bus.nop = 1'b0;
   endtask

   task automatic test_reset();
      cycle(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, '0);
      cycle(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, '0);
      checks++;
      if (bus.curWnd !== 2'd0) begin
         failures++; $display("FAIL reset_cwp got=%0d exp=0", bus.curWnd);
      end
      for (int a = 0; a < 4; a++) begin
         bus.rdAddr0 = 2'(a); bus.rdAddr1 = 2'(3 - a); #1;
         checks++;
         if (bus.rdData0 !== 8'h00 || bus.rdData1 !== 8'h00) begin
            failures++;
            $display("FAIL reset_read a=%0d got=%h/%h exp=00/00", a, bus.rdData0, bus.rdData1);
         end
      end
   endtask

   task automatic test_write_basic();
      logic [WIDTH-1:0] exp;
      cycle(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd1, 8'hA5);
      checks++;
      if (bus.curWnd !== 2'd0) begin
         failures++; $display("FAIL basic_cwp got=%0d exp=0", bus.curWnd);
      end
      // Visit every window so all 8 physical registers are observed.
      for (int w = 0; w < 4; w++) begin
         cycle(1'b0, 1'b1, 2'(w), 1'b0, 1'b0, 2'd0, '0);
         for (int a = 0; a < 4; a++) begin
            exp = (((2 * w + a) % 8) == 1) ? 8'hA5 : 8'h00;
            bus.rdAddr0 = 2'(a); bus.rdAddr1 = 2'(a); #1;
            checks++;
            if (bus.rdData0 !== exp || bus.rdData1 !== exp) begin
               failures++;
               $display("FAIL basic_read w=%0d r=%0d got=%h/%h exp=%h", w, a, bus.rdData0, bus.rdData1, exp);
            end
         end
      end
      cycle(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, '0);
   endtask

   task automatic test_overlap();
      logic [WIDTH-1:0] exp [4];
      exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h00; exp[3] = 8'h00;
      cycle(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd2, 8'h11);
      cycle(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd3, 8'h22);
      cycle(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 2'd0, '0);
      checks++;
      if (bus.curWnd !== 2'd1) begin
         failures++; $display("FAIL overlap_cwp got=%0d exp=1", bus.curWnd);
      end
      for (int a = 0; a < 4; a++) begin
         bus.rdAddr0 = 2'(a); #1;
         checks++;
         if (bus.rdData0 !== exp[a]) begin
            failures++; $display("FAIL overlap_r%0d got=%h exp=%h", a, bus.rdData0, exp[a]);
         end
      end
   endtask

   task automatic test_wrap();
      cycle(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 2'd0, '0);
      cycle(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd2, 8'h3C);
      cycle(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, '0);
      bus.rdAddr1 = 2'd0; #1;
      checks++;
      if (bus.rdData1 !== 8'h3C) begin
         failures++; $display("FAIL wrap_p0 got=%h exp=3c", bus.rdData1);
      end
      cycle(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 2'd0, '0);
      bus.rdAddr1 = 2'd3; #1;
      checks++;
      if (bus.rdData1 !== 8'hA5) begin
         failures++; $display("FAIL wrap_p1 got=%h exp=a5", bus.rdData1);
      end
   endtask

   task automatic test_nop_gating();
      cycle(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, '0);
      cycle(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 8'hFF);
      bus.rdAddr0 = 2'd0; #1;
      checks++;
      if (bus.rdData0 !== 8'h00) begin
         failures++; $display("FAIL nop_blocked got=%h exp=00", bus.rdData0);
      end
      cycle(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 8'hFF);
      checks++;
      if (bus.rdData0 !== 8'hFF) begin
         failures++; $display("FAIL nop_pass got=%h exp=ff", bus.rdData0);
      end
   endtask

   task automatic test_simultaneous();
      cycle(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, '0);
      cycle(1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 2'd0, 8'h77);
      bus.rdAddr0 = 2'd0; #1;
      checks++;
      if (bus.curWnd !== 2'd2 || bus.rdData0 !== 8'h00) begin
         failures++;
         $display("FAIL simul_new_window got=cwp%0d/%h exp=cwp2/00", bus.curWnd, bus.rdData0);
      end
      cycle(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, '0);
      checks++;
      if (bus.rdData0 !== 8'h77) begin
         failures++; $display("FAIL simul_old_window got=%h exp=77", bus.rdData0);
      end
   endtask

   task automatic test_reset_mid();
      for (int a = 0; a < 4; a++) cycle(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'(a), 8'(8'h40 + a));
      cycle(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 2'd0, '0);
      cycle(1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 2'd2, 8'h55);
      checks++;
      if (bus.curWnd !== 2'd0) begin
         failures++; $display("FAIL rstmid_cwp got=%0d exp=0", bus.curWnd);
      end
      for (int w = 0; w < 4; w++) begin
         if (w != 0) cycle(1'b0, 1'b1, 2'(w), 1'b0, 1'b0, 2'd0, '0);
         for (int a = 0; a < 4; a++) begin
            bus.rdAddr0 = 2'(a); #1;
            checks++;
            if (bus.rdData0 !== 8'h00) begin
               failures++; $display("FAIL rstmid_read w=%0d r=%0d got=%h exp=00", w, a, bus.rdData0);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         rst          = ($urandom_range(0, 39) == 0);
         bus.ldWnd    = ($urandom_range(0, 3) == 0);
         bus.window   = 2'($urandom);
         bus.regWrite = 1'($urandom);
         bus.nop      = ($urandom_range(0, 3) != 0);
         bus.wrAddr   = 2'($urandom);
         bus.wrData   = 8'($urandom);
         bus.rdAddr0  = 2'($urandom);
         bus.rdAddr1  = 2'($urandom);
         #1;
         // Pre-edge reads reflect old contents even when a write is pending.
         checks++;
         if (bus.rdData0 !== model_read(bus.rdAddr0) || bus.rdData1 !== model_read(bus.rdAddr1)
             || bus.curWnd !== 2'(model_cwp)) begin
            failures++;
            $display("FAIL rand_%0d got=%h/%h cwp%0d exp=%h/%h cwp%0d", n, bus.rdData0, bus.rdData1,
                     bus.curWnd, model_read(bus.rdAddr0), model_read(bus.rdAddr1), model_cwp);
         end
         step();
      end
      rst = 1'b0; bus.ldWnd = 1'b0; bus.regWrite = 1'b0; bus.nop = 1'b0;
   endtask

   initial begin
      checks = 0; failures = 0;
      model_cwp = 0;
      for (int i = 0; i < 8; i++) model_phys[i] = '0;
      rst = 1'b1; bus.ldWnd = 1'b0; bus.window = 2'd0; bus.regWrite = 1'b0; bus.nop = 1'b0;
      bus.wrAddr = 2'd0; bus.wrData = '0; bus.rdAddr0 = 2'd0; bus.rdAddr1 = 2'd0;
      @(posedge clk); #1;
      test_reset();
      test_write_basic();
      test_overlap();
      test_wrap();
      test_nop_gating();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/window_reg_file.md
Name: window_reg_file

Overview:
Windowed register file directly downstream of the ALU control decoder. It consumes the decoder's window select, ldWnd and nop outputs, holds the current window pointer (CWP), and maps logical registers R0..R3 of the active window onto 8 overlapping physical registers. It supplies both ALU operands and takes the ALU result write-back in the single-cycle datapath.

Parameters:
WIDTH, 8, data width of each physical register and of all data ports.

Ports:
clk  input  1  single system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
window  input  2  window number from the decoder (func[1:0]).
ldWnd  input  1  load CWP from window at next edge.
nop  input  1  decoder's active-high execute qualifier; 0 means NOP or window instruction, so write-back is blocked.
regWrite  input  1  write-back request from the main controller.
wrAddr  input  2  logical destination register.
wrData  input  WIDTH  write-back data (ALU result).
rdAddr0  input  2  logical source register A.
rdAddr1  input  2  logical source register B.
rdData0  output  WIDTH  contents of the register selected by rdAddr0.
rdData1  output  WIDTH  contents of the register selected by rdAddr1.
curWnd  output  2  current CWP value.

Behaviour:
- State: CWP (2 bits) and phys[0..7] (WIDTH bits each). No other state.
- Mapping: physical index = (2*CWP + logical) mod 8, computed in 3-bit arithmetic with wrap.
  - Window 0: R0..R3 map to P0..P3.
  - Window 1: R0..R3 map to P2..P5.
  - Window 2: R0..R3 map to P4..P7.
  - Window 3: R0..R3 map to P6, P7, P0, P1.
  - Adjacent windows share two registers: the caller's R2/R3 are the callee's R0/R1.
- Reset: when rst=1 at an edge, CWP←0 and all phys←0. rst overrides ldWnd and write in the same cycle. Following reset, curWnd=0 and rdData0=rdData1=0.
- Window load: at the edge where ldWnd=1 (and rst=0), CWP←window. This is independent of nop and regWrite.
- Write: effective write enable we = regWrite & nop & ~rst.
  - At the edge where we=1, phys[map(CWP, wrAddr)]←wrData.
  - The mapping uses the CWP value present before that edge.
- Simultaneous ldWnd and we at the same edge: the write goes through the old window; CWP updates at the same edge. The decoder never produces this combination, but the behaviour is defined.
- ldWnd with window equal to the current CWP: no visible change.
- Reads: rdData0 and rdData1 are combinational from the current CWP, rdAddr and phys. Zero latency.
  - No write-through bypass. A read in the cycle of a write returns the old value; the new value is visible after the edge.
  - Both read ports may select the same register.
- Latency:
  - Write is visible on reads 1 cycle after the write edge.
  - A CWP change affects the read mapping and curWnd 1 cycle after the ldWnd edge.
- Nothing else changes state. With nop=0 and ldWnd=0, the block holds.

Test Plan:
1. Reset then write: rst for 2 cycles, then regWrite=1, nop=1, wrAddr=1, wrData=8'hA5 in window 0 -> after the edge rdAddr0=1 gives 8'hA5; the other 7 registers read 0; curWnd=0.
2. Overlap: in window 0 write R2=8'h11 and R3=8'h22; ldWnd=1, window=1 -> next cycle curWnd=1, R0 reads 8'h11, R1 reads 8'h22, R2 and R3 read 0.
3. Wrap-around: window 3, write R2=8'h3C -> switch to window 0, R0 reads 8'h3C (P0). Back in window 3, R3 maps to P1.
4. NOP gating: regWrite=1, nop=0, wrAddr=0, wrData=8'hFF -> R0 unchanged (still 0). Repeat with nop=1 -> R0=8'hFF.
5. Simultaneous load and write: CWP=0; in one cycle ldWnd=1, window=2, regWrite=1, nop=1, wrAddr=0, wrData=8'h77 -> P0=8'h77 and P4 unchanged; curWnd=2; R0 now reads P4 (0).
6. Reset mid-operation: with registers populated and CWP=3, assert rst together with regWrite=1 and ldWnd=1 -> after the edge all reads are 0, curWnd=0, and the write is discarded.
